// File: rtl/mux2_rr_arbiter_if.sv
// Handshake and data bundle between two requesters and the shared 2:1 mux arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface mux2_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req_a;
    logic              req_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              sel;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;

    modport master (
        output req_a, req_b, data_a, data_b,
        input  gnt_a, gnt_b, sel, out_data, out_valid, busy
    );

    modport slave (
        input  req_a, req_b, data_a, data_b,
        output gnt_a, gnt_b, sel, out_data, out_valid, busy
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-requester arbiter for a shared 2:1 mux: round-robin ties, burst limit while the other side waits.
// Define ARB_FIXED_PRIO_EN for A-priority ties and no burst limit on A ownership.
module mux2_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mux2_rr_arbiter_if.slave      bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic              last_owner_q, last_owner_d;   // 0 = A, 1 = B
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic              sel_q, sel_d;
    logic              a_limit_hit;
    logic              b_limit_hit;
    logic [DATA_W-1:0] mux_out;

`ifdef ARB_FIXED_PRIO_EN
    assign a_limit_hit = 1'b0;
`else
    assign a_limit_hit = (burst_cnt_q >= BURST_LAST);
`endif
    assign b_limit_hit = (burst_cnt_q >= BURST_LAST);

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = '0;
        last_owner_d = last_owner_q;

        case (state_q)
            IDLE: begin
                if (bus.req_a && bus.req_b) begin
`ifdef ARB_FIXED_PRIO_EN
                    state_d = OWN_A;
`else
                    state_d = last_owner_q ? OWN_A : OWN_B;
`endif
                end else if (bus.req_a) begin
                    state_d = OWN_A;
                end else if (bus.req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (bus.req_a) begin
                    if (bus.req_b && a_limit_hit) state_d = OWN_B;
                end else if (bus.req_b) begin
                    state_d = OWN_B;
                end else begin
                    state_d = IDLE;
                end
                // Counter only runs while staying put with B waiting; any entry clears it.
                if (state_d == OWN_A && bus.req_b) burst_cnt_d = burst_cnt_q + 8'd1;
            end
            OWN_B: begin
                if (bus.req_b) begin
                    if (bus.req_a && b_limit_hit) state_d = OWN_A;
                end else if (bus.req_a) begin
                    state_d = OWN_A;
                end else begin
                    state_d = IDLE;
                end
                if (state_d == OWN_B && bus.req_a) burst_cnt_d = burst_cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == OWN_A) last_owner_d = 1'b0;
        if (state_d == OWN_B) last_owner_d = 1'b1;
    end

    always_comb begin
        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
        sel_d   = sel_q;
        if (state_d == OWN_A) sel_d = 1'b0;
        if (state_d == OWN_B) sel_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            burst_cnt_q  <= '0;
            last_owner_q <= 1'b1;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            sel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            sel_q        <= sel_d;
        end
    end

    always_comb begin
        mux_out = sel_q ? bus.data_b : bus.data_a;
    end

    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.sel       = sel_q;
    assign bus.out_data  = mux_out;
    assign bus.out_valid = gnt_a_q | gnt_b_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
